// File: rtl/tcb_img_feeder.sv
// Byte-stream front end for the 121x8 classifier: packs a frame into the flat image
// vector, hands it to the classifier, waits (bounded) for its answer and returns it.
module tcb_img_feeder #(
  parameter int unsigned NPIX    = 121,
  parameter int unsigned PW      = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PW-1:0]      pix_in,
  input  logic               pix_valid,
  input  logic               pix_last,
  output logic               pix_ready,
  output logic [NPIX*PW-1:0] img_source,
  output logic               valid_top,
  input  logic               ready_top,
  input  logic [7:0]         number,
  output logic [7:0]         res_number,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_timeout,
  output logic               frame_err
);

  localparam int unsigned CW = $clog2(NPIX);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);
  localparam logic [TW-1:0] TMO_LIM  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_SEND,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [TW-1:0]       tmo_q;
  logic [NPIX*PW-1:0]  img_q;
  logic                pix_ready_q;
  logic                valid_top_q;
  logic [7:0]          res_number_q;
  logic                res_valid_q;
  logic                res_timeout_q;
  logic                frame_err_q;

  logic                xfer;
  logic [CW-1:0]       slot;

  assign xfer = pix_valid & pix_ready_q;
  // Arrival order maps MSB-first: pixel 0 occupies the top byte of the vector.
  assign slot = LAST_IDX - cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FILL;
      cnt_q         <= '0;
      tmo_q         <= '0;
      img_q         <= '0;
      pix_ready_q   <= 1'b0;
      valid_top_q   <= 1'b0;
      res_number_q  <= '0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          pix_ready_q <= 1'b1;
          if (xfer) begin
            if (cnt_q == LAST_IDX) begin
              img_q[slot*PW +: PW] <= pix_in;
              cnt_q       <= '0;
              tmo_q       <= '0;
              pix_ready_q <= 1'b0;
              valid_top_q <= 1'b1;
              state_q     <= S_SEND;
              if (!pix_last) frame_err_q <= 1'b1;
            end else if (pix_last) begin
              // Short frame: drop it and restart counting; stale bytes get overwritten.
              frame_err_q <= 1'b1;
              cnt_q       <= '0;
            end else begin
              img_q[slot*PW +: PW] <= pix_in;
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        S_SEND: begin
          // The SEND cycle already counts toward the classifier deadline.
          tmo_q   <= tmo_q + 1'b1;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (ready_top) begin
            res_number_q  <= number;
            res_timeout_q <= 1'b0;
            valid_top_q   <= 1'b0;
            res_valid_q   <= 1'b1;
            state_q       <= S_RESULT;
          end else if (tmo_q == TMO_LIM) begin
            res_number_q  <= 8'hFF;
            res_timeout_q <= 1'b1;
            valid_top_q   <= 1'b0;
            res_valid_q   <= 1'b1;
            state_q       <= S_RESULT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        S_RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            tmo_q       <= '0;
            pix_ready_q <= 1'b1;
            state_q     <= S_FILL;
          end
        end

        default: state_q <= S_FILL;
      endcase
    end
  end

  assign pix_ready   = pix_ready_q;
  assign img_source  = img_q;
  assign valid_top   = valid_top_q;
  assign res_number  = res_number_q;
  assign res_valid   = res_valid_q;
  assign res_timeout = res_timeout_q;
  assign frame_err   = frame_err_q;

endmodule
